// File: rtl/decouple_fifo.sv
// Decoupling FIFO between two valid/ready channels: any integer DEPTH, occupancy count,
// almost-full flag and synchronous flush. Registered-only output controls, no din->dout bypass.
module decouple_fifo #(
  parameter int DIN       = 16,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DIN-1:0]             din_data,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [DIN-1:0]             dout_data,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  // Handshake: a word moves on a rising edge when valid and ready are both high in
  // the preceding cycle; valid never waits on ready, and a held head word stays stable.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DIN-1:0] mem [DEPTH];
  logic [PW-1:0]  w_ptr;
  logic [PW-1:0]  r_ptr;
  logic [CW-1:0]  count_q;
  logic           full;
  logic           wr;
  logic           rd;

  // Outputs are gated by rst so they read idle while reset is held, even before the first edge.
  assign full        = (count_q == CW'(DEPTH));
  assign din_ready   = rst & ~full & ~flush;
  assign dout_valid  = rst & (count_q != '0);
  assign count       = rst ? count_q : '0;
  assign almost_full = rst & (count_q >= CW'(AFULL_LVL));
  assign dout_data   = mem[r_ptr];

  assign wr = din_valid & din_ready;
  assign rd = dout_valid & dout_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
    end else if (flush) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
    end else begin
      if (wr) w_ptr <= ptr_inc(w_ptr);
      if (rd) r_ptr <= ptr_inc(r_ptr);
      case ({wr, rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; wr already excludes reset and flush cycles.
  always_ff @(posedge clk) begin
    if (wr) mem[w_ptr] <= din_data;
  end

endmodule

// File: tb/tb_decouple_fifo.sv
// Randomised bench for decouple_fifo (DEPTH=5): a queue-based reference model feeds an
// expected-data queue that a negedge monitor compares against the DUT outputs.
module tb_decouple_fifo;

  localparam int DIN   = 16;
  localparam int DEPTH = 5;
  localparam int AFULL = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [DIN-1:0] din_data;
  logic           din_valid;
  logic           din_ready;
  logic [DIN-1:0] dout_data;
  logic           dout_valid;
  logic           dout_ready;
  logic [CW-1:0]  count;
  logic           almost_full;

  logic [DIN-1:0] exp_q[$];
  int             m_cnt     = 0;
  int             acc_total = 0;
  int             checks    = 0;
  int             passes    = 0;

  decouple_fifo #(.DIN(DIN), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of at most DEPTH words, updated at every rising edge.
  always @(posedge clk) begin
    if (!rst || flush) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      bit acc, deq;
      acc = din_valid && (m_cnt < DEPTH);
      deq = dout_ready && (m_cnt > 0);
      if (acc) begin
        exp_q.push_back(din_data);
        acc_total++;
      end
      m_cnt = m_cnt + int'(acc) - int'(deq);
    end
  end

  // Monitor: compares flags every cycle and the head word whenever one is presented.
  always @(negedge clk) begin
    chk("din_ready",   32'(din_ready),   32'(rst && !flush && m_cnt < DEPTH));
    chk("dout_valid",  32'(dout_valid),  32'(rst && m_cnt != 0));
    chk("count",       32'(count),       rst ? 32'(m_cnt) : 32'd0);
    chk("almost_full", 32'(almost_full), 32'(rst && m_cnt >= AFULL));
    if (dout_valid) begin
      if (exp_q.size() == 0) chk("dout_valid_no_expected_word", 32'(dout_valid), 32'd0);
      else begin
        chk("dout_data", 32'(dout_data), 32'(exp_q[0]));
        if (dout_ready && rst && !flush) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic v, input logic [DIN-1:0] d,
                       input logic rdy);
    rst = r; flush = f; din_valid = v; din_data = d; dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && m_cnt > 0; i++) drive(1, 0, 0, '0, 1);
    chk("drain_empty", 32'(count), 32'd0);
  endtask

  logic [DIN-1:0] stall_head;

  initial begin
    rst = 0; flush = 0; din_valid = 1; din_data = 16'h1234; dout_ready = 1;
    // Reset held with a pending write
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 16'h1234, 1);

    // Fill 1..5 with no reads, one refused write, then drain in order
    for (int i = 1; i <= DEPTH; i++) drive(1, 0, 1, DIN'(i), 0);
    drive(1, 0, 1, 16'h00ff, 0);
    drain(20);

    // Streaming with random 50% valid/ready until 23 words accepted
    begin
      int start = acc_total;
      int cyc = 0;
      while (acc_total - start < 23 && cyc < 500) begin
        drive(1, 0, 1'($urandom_range(0, 1)), DIN'($urandom), 1'($urandom_range(0, 1)));
        cyc++;
      end
      chk("stream_accepted_23", 32'(acc_total - start >= 23), 32'd1);
      drain(20);
    end

    // Full with simultaneous valid/ready: write refused, slot freed next cycle
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 1, DIN'(16'h0a00 + i), 0);
    drive(1, 0, 1, 16'haaaa, 1);
    drive(1, 0, 1, 16'haaaa, 0);
    drain(20);

    // Back-pressure stall: head must hold while writes continue
    drive(1, 0, 1, 16'h5a5a, 0);
    stall_head = 16'h5a5a;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, DIN'($urandom), 0);
      chk("stall_head_hold", 32'(dout_data), 32'(stall_head));
    end
    drain(20);

    // Flush with concurrent read and write, then 0xBEEF emerges first
    for (int i = 0; i < 3; i++) drive(1, 0, 1, DIN'(16'h0300 + i), 0);
    drive(1, 1, 1, 16'hdead, 1);
    chk("flush_count", 32'(count), 32'd0);
    drive(1, 0, 1, 16'hbeef, 0);
    chk("after_flush_head", 32'(dout_data), 32'h0000beef);
    drain(20);

    // Mixed random traffic with occasional flush and reset mid-transfer
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)), DIN'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    drive(1, 0, 0, '0, 1);
    drain(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
